mem_bus_arbiter: RTL and testbench

- Shares the single 8-bit RAM/ROM bus between two requesters: port 0 is the CPU fetch/execute path, driven from the control state machine's rd/wr/addr; port 1 is the DMA/program loader.
- Sequences every access as a fixed-length, wait-stated bus cycle.
- Guarantees rd and wr are never asserted together, and inserts a turnaround cycle between accesses.
- Sits between the CPU address/data muxes and the memory blocks.

---
 rtl/cpu_bus_pkg.sv | 17 +
 rtl/arb_rr2.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: FSM state encoding, default
// bus widths and requester port indices.
package cpu_bus_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational request picker: round-robin on last_gnt by default,
// fixed CPU priority when MEM_ARB_CPU_PRI_EN is defined.
module arb_rr2
    import cpu_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner,
    output logic any
);

    assign any = req0 | req1;

`ifdef MEM_ARB_CPU_PRI_EN
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = last_gnt;
    assign winner = req0 ? PORT_CPU : PORT_DMA;
`else
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req0) begin
            winner = PORT_CPU;
        end else begin
            winner = PORT_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with fixed-length wait-stated accesses and a
// turnaround cycle between them. Define MEM_ARB_CPU_PRI_EN for CPU priority.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int WAIT_CYC = 1
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    localparam logic       ZERO_WAIT = (WAIT_CYC == 0);

    state_t        r_state, w_state_next;
    logic [3:0]    r_wcnt, w_wcnt_next;
    logic          r_last_gnt, w_last_gnt_next;
    logic          r_port, w_port_next;
    logic          r_mem_rd, w_mem_rd_next;
    logic          r_mem_wr, w_mem_wr_next;
    logic [AW-1:0] r_mem_addr, w_mem_addr_next;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_next;
    logic [DW-1:0] r_rdata0, w_rdata0_next;
    logic [DW-1:0] r_rdata1, w_rdata1_next;
    logic          r_gnt0, w_gnt0_next;
    logic          r_gnt1, w_gnt1_next;
    logic          r_done0, w_done0_next;
    logic          r_done1, w_done1_next;

    logic          w_winner, w_any, w_grant, w_grant_port;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    arb_rr2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (r_last_gnt),
        .winner   (w_winner),
        .any      (w_any)
    );

    assign w_sel_we    = w_grant_port ? we1    : we0;
    assign w_sel_addr  = w_grant_port ? addr1  : addr0;
    assign w_sel_wdata = w_grant_port ? wdata1 : wdata0;

    always_comb begin
        w_state_next     = r_state;
        w_wcnt_next      = r_wcnt;
        w_last_gnt_next  = r_last_gnt;
        w_port_next      = r_port;
        w_mem_rd_next    = r_mem_rd;
        w_mem_wr_next    = r_mem_wr;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_rdata0_next    = r_rdata0;
        w_rdata1_next    = r_rdata1;
        w_gnt0_next      = 1'b0;
        w_gnt1_next      = 1'b0;
        w_done0_next     = 1'b0;
        w_done1_next     = 1'b0;
        w_grant          = 1'b0;
        w_grant_port     = w_winner;

        case (r_state)
            ST_IDLE: begin
                w_grant = w_any;
            end
            ST_ACCESS: begin
                // done is registered, so it is raised one cycle ahead of wcnt reaching 0
                if (r_wcnt != 4'd0) begin
                    w_wcnt_next = r_wcnt - 4'd1;
                    if (r_wcnt == 4'd1) begin
                        w_done0_next = (r_port == PORT_CPU);
                        w_done1_next = (r_port == PORT_DMA);
                    end
                end else begin
                    w_mem_rd_next = 1'b0;
                    w_mem_wr_next = 1'b0;
                    w_state_next  = ST_TURN;
                    if (r_mem_rd) begin
                        if (r_port == PORT_CPU) begin
                            w_rdata0_next = mem_rdata;
                        end else begin
                            w_rdata1_next = mem_rdata;
                        end
                    end
                end
            end
            ST_TURN: begin
                w_state_next = ST_IDLE;
`ifdef MEM_ARB_CPU_PRI_EN
                if (r_port == PORT_CPU && req0) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_CPU;
                end
`endif
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_grant) begin
            w_state_next     = ST_ACCESS;
            w_port_next      = w_grant_port;
            w_last_gnt_next  = w_grant_port;
            w_wcnt_next      = WAIT_INIT;
            w_mem_rd_next    = ~w_sel_we;
            w_mem_wr_next    = w_sel_we;
            w_mem_addr_next  = w_sel_addr;
            w_mem_wdata_next = w_sel_wdata;
            w_gnt0_next      = (w_grant_port == PORT_CPU);
            w_gnt1_next      = (w_grant_port == PORT_DMA);
            w_done0_next     = ZERO_WAIT && (w_grant_port == PORT_CPU);
            w_done1_next     = ZERO_WAIT && (w_grant_port == PORT_DMA);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= 4'd0;
            r_last_gnt  <= PORT_DMA;
            r_port      <= PORT_CPU;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wcnt      <= w_wcnt_next;
            r_last_gnt  <= w_last_gnt_next;
            r_port      <= w_port_next;
            r_mem_rd    <= w_mem_rd_next;
            r_mem_wr    <= w_mem_wr_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_rdata0    <= w_rdata0_next;
            r_rdata1    <= w_rdata1_next;
            r_gnt0      <= w_gnt0_next;
            r_gnt1      <= w_gnt1_next;
            r_done0     <= w_done0_next;
            r_done1     <= w_done1_next;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

    a_no_rd_wr:   assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_wr));
    a_one_grant:  assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: randomized two-port traffic against a
// per-port reference memory, plus fairness, reset and wait-state width checks.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req   [2];
    logic        we    [2];
    logic [12:0] addr  [2];
    logic [7:0]  wdata [2];
    logic        gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy;
    logic [7:0]  rdata0, rdata1, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;

    logic [7:0]  ram [0:8191];
    logic [7:0]  ref_mem [int];

    int n_tests = 0;
    int n_fail  = 0;

    txn_t q0 [$];
    txn_t q1 [$];
    int   gnt_log [$];
    time  gnt_t   [$];

    function automatic logic [7:0] fdef(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [12:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fdef(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    mem_bus_arbiter #(.AW(13), .DW(8), .WAIT_CYC(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;

    // Extra instances for the wait-state extremes: index 0 -> WAIT_CYC=0, 1 -> 15.
    logic        xreq [2], xwe [2];
    logic [12:0] xaddr [2], xmaddr [2];
    logic [7:0]  xwdata [2], xrdata0 [2], xrdata1 [2], xmwdata [2], xmrdata [2];
    logic        xgnt0 [2], xgnt1 [2], xdone0 [2], xdone1 [2], xrd [2], xwr [2], xbusy [2];
    logic [7:0]  xmodel [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wdut
            mem_bus_arbiter #(.AW(13), .DW(8), .WAIT_CYC(gi == 0 ? 0 : 15)) u_w (
                .clk(clk), .reset(reset),
                .req0(xreq[gi]), .we0(xwe[gi]), .addr0(xaddr[gi]), .wdata0(xwdata[gi]),
                .gnt0(xgnt0[gi]), .done0(xdone0[gi]), .rdata0(xrdata0[gi]),
                .req1(1'b0), .we1(1'b0), .addr1(13'h0000), .wdata1(8'h00),
                .gnt1(xgnt1[gi]), .done1(xdone1[gi]), .rdata1(xrdata1[gi]),
                .mem_rd(xrd[gi]), .mem_wr(xwr[gi]), .mem_addr(xmaddr[gi]),
                .mem_wdata(xmwdata[gi]), .mem_rdata(xmrdata[gi]), .busy(xbusy[gi])
            );
            assign xmrdata[gi] = fdef(xmaddr[gi]);
        end
    endgenerate

    // Monitor: tracks each access from grant to done and pops the scoreboard.
    logic        in_acc = 1'b0, cur_p, cur_we, bad, rd_pend = 1'b0, rd_p, turn_chk = 1'b0;
    logic [12:0] cur_addr;
    logic [7:0]  cur_wdata, rd_exp;
    logic [7:0]  model_rd [2];
    int          scnt;
    txn_t        mon_t;

    always @(negedge clk) begin
        if (reset) begin
            in_acc = 1'b0; rd_pend = 1'b0; turn_chk = 1'b0;
            model_rd[0] = 8'h00; model_rd[1] = 8'h00;
        end else begin
            if (mem_rd && mem_wr) begin
                n_tests++; n_fail++;
                $display("FAIL rd_wr_overlap: got mem_rd=1 mem_wr=1, expected exclusive");
            end
            if (gnt0 && gnt1) begin
                n_tests++; n_fail++;
                $display("FAIL double_grant: got gnt0=1 gnt1=1, expected one-hot");
            end
            if (rd_pend) begin
                check($sformatf("rdata%0d", rd_p), rd_p ? rdata1 : rdata0, rd_exp);
                rd_pend = 1'b0;
            end
            if (turn_chk) begin
                check("turn_idle", {gnt0 | gnt1, mem_rd | mem_wr}, 0);
                turn_chk = 1'b0;
            end
            if (gnt0 || gnt1) begin
                if (in_acc) begin
                    n_tests++; n_fail++;
                    $display("FAIL grant_overlap: got grant during access, expected none");
                end
                in_acc = 1'b1; cur_p = gnt1; cur_we = mem_wr; cur_addr = mem_addr;
                cur_wdata = mem_wdata; scnt = 0; bad = 1'b0;
                gnt_log.push_back(int'(gnt1));
                gnt_t.push_back($time);
            end
            if (in_acc) begin
                scnt++;
                if (mem_rd !== !cur_we || mem_wr !== cur_we || mem_addr !== cur_addr ||
                    (cur_we && mem_wdata !== cur_wdata))
                    bad = 1'b1;
                if (done0 || done1) begin
                    check("done_port", {done1, done0}, cur_p ? 2'b10 : 2'b01);
                    check("strobe_width", scnt, 2);
                    check("strobe_stable", bad, 0);
                    if ((cur_p ? q1.size() : q0.size()) == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL scoreboard_empty: got access on port%0d, expected none", cur_p);
                    end else begin
                        if (cur_p) mon_t = q1.pop_front();
                        else       mon_t = q0.pop_front();
                        check("addr", cur_addr, mon_t.addr);
                        check("we", cur_we, mon_t.we);
                        if (mon_t.we) begin
                            check("wdata", cur_wdata, mon_t.wdata);
                            rd_exp = model_rd[cur_p];
                        end else begin
                            rd_exp = mon_t.rdata;
                            model_rd[cur_p] = mon_t.rdata;
                        end
                        rd_pend = 1'b1; rd_p = cur_p;
                        $display("[TB] port%0d %s addr=%h wdata=%h exp_rdata=%h", cur_p,
                                 mon_t.we ? "WR" : "RD", mon_t.addr, mon_t.wdata, rd_exp);
                    end
                    in_acc = 1'b0; turn_chk = 1'b1;
                end
            end else if (done0 || done1) begin
                n_tests++; n_fail++;
                $display("FAIL stray_done: got done0=%0d done1=%0d, expected 0", done0, done1);
            end
        end
    end

    task automatic do_access(input int p, input logic w, input logic [12:0] a,
                             input logic [7:0] d, input bit drop, output int lat);
        txn_t t;
        bit   ok;
        t.we = w; t.addr = a; t.wdata = d;
        t.rdata = w ? 8'h00 : ref_rd(a);
        if (w) ref_mem[int'(a)] = d;
        if (p == 0) q0.push_back(t);
        else        q1.push_back(t);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        ok = 1'b0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin ok = 1'b1; lat = i; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_timeout: got no gnt%0d, expected one", p);
            req[p] = 1'b0;
            return;
        end
        if (drop) begin
            @(posedge clk); #1;
            req[p] = 1'b0; addr[p] = ~a; we[p] = ~w; wdata[p] = ~d;
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((p == 0) ? done0 : done1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done%0d, expected one", p);
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic run_port(input int p, input int n);
        int          d, lat;
        logic [11:0] lo;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, 3);
            if (d > 0) begin
                repeat (d) @(posedge clk);
                #1;
            end
            lo = ($urandom_range(0, 1) != 0 ? 12'hFFF : 12'h000) ^ 12'($urandom_range(0, 7));
            do_access(p, 1'($urandom_range(0, 1)), {p[0], lo}, 8'($urandom),
                      ($urandom_range(0, 3) == 0), lat);
        end
    endtask

    task automatic measure(input int k, input int w, input logic wr);
        int          width, done_at, done_cnt;
        bit          ok, bad_bus;
        logic [12:0] a;
        logic [7:0]  d;
        a = 13'($urandom); d = 8'($urandom);
        xaddr[k] = a; xwe[k] = wr; xwdata[k] = d; xreq[k] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xgnt0[k]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL w%0d_gnt_timeout: got no gnt, expected one", w);
            xreq[k] = 1'b0;
            return;
        end
        width = 0; done_at = 0; done_cnt = 0; bad_bus = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!(wr ? xwr[k] : xrd[k])) break;
            width++;
            if (xdone0[k]) begin done_at = width; done_cnt++; end
            if (xmaddr[k] !== a || (wr && xmwdata[k] !== d) || (xrd[k] && xwr[k])) bad_bus = 1'b1;
            @(posedge clk); #1;
            xreq[k] = 1'b0;
            @(negedge clk);
        end
        check($sformatf("w%0d_%s_width", w, wr ? "wr" : "rd"), width, w + 1);
        check($sformatf("w%0d_done_at", w), done_at, w + 1);
        check($sformatf("w%0d_done_count", w), done_cnt, 1);
        check($sformatf("w%0d_bus_stable", w), bad_bus, 0);
        if (!wr) xmodel[k] = fdef(a);
        check($sformatf("w%0d_rdata", w), xrdata0[k], xmodel[k]);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("w%0d_idle", w), {xbusy[k], xgnt1[k], xdone1[k], xrdata1[k]}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, lat;
        for (int i = 0; i < 8192; i++) ram[i] = fdef(13'(i));
        ram[16] = 8'hA5;
        ref_mem[16] = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            xreq[k] = 1'b0; xwe[k] = 1'b0; xaddr[k] = '0; xwdata[k] = '0; xmodel[k] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy}, 0);
        check("reset_bus", {mem_addr, mem_wdata}, 0);
        check("reset_rdata", {rdata0, rdata1}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access(0, 1'b0, 13'h0010, 8'h00, 1'b0, lat);
        check("gnt0_latency", lat, 1);
        check("rdata0_directed", rdata0, 8'hA5);
        do_access(1, 1'b1, 13'h1FFF, 8'h3C, 1'b0, lat);
        do_access(0, 1'b0, 13'h0011, 8'h00, 1'b1, lat);
        repeat (4) @(posedge clk);
        #1;

        fork
            run_port(0, 40);
            run_port(1, 40);
        join
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", q0.size() + q1.size(), 0);

        // Fairness from reset: both ports held for six accesses.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        s = gnt_log.size();
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{1'b0, 13'h0020, 8'h00, ref_rd(13'h0020)});
            q1.push_back('{1'b0, 13'h1020, 8'h00, ref_rd(13'h1020)});
        end
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 13'h0020;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 13'h1020;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt_log.size() >= s + 6) break;
        end
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("fair_count", gnt_log.size() - s, 6);
        for (int i = 0; i < 6; i++) begin
            if (s + i < gnt_log.size()) begin
                check($sformatf("fair_order%0d", i), gnt_log[s + i], i % 2);
                if (i > 0)
                    check($sformatf("grant_spacing%0d", i), 32'(gnt_t[s + i] - gnt_t[s + i - 1]), 40);
            end
        end

        // Reset in the middle of an access.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 13'h1055;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt1) break;
        end
        check("mid_gnt1_seen", gnt1, 1);
        #2;
        reset = 1'b1; req[1] = 1'b0;
        #1;
        check("async_reset_ctl", {gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy}, 0);
        check("async_reset_bus", {mem_addr, mem_wdata}, 0);
        check("async_reset_rdata", {rdata0, rdata1}, 0);
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        s = gnt_log.size();
        fork
            begin int l0; do_access(0, 1'b0, 13'h0030, 8'h00, 1'b0, l0); end
            begin int l1; do_access(1, 1'b0, 13'h1030, 8'h00, 1'b0, l1); end
        join
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_count", gnt_log.size() - s, 2);
        if (gnt_log.size() >= s + 2) begin
            check("post_reset_first", gnt_log[s], 0);
            check("post_reset_second", gnt_log[s + 1], 1);
        end

        measure(0, 0, 1'b0);
        measure(0, 0, 1'b1);
        measure(1, 15, 1'b0);
        measure(1, 15, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
